// File: rtl/rgb_pwm_driver.sv
// Three-channel 8-bit PWM driver for an RGB LED fed from the lights selector word {R,G,B}.
// Optional build macro FULL_ON_EN: duty 8'hFF holds a channel continuously high.
module rgb_pwm_driver #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [23:0] light,
  output logic        pwm_r,
  output logic        pwm_g,
  output logic        pwm_b,
  output logic        period_start
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;
  logic [7:0]    cnt;
  logic [7:0]    duty_r;
  logic [7:0]    duty_g;
  logic [7:0]    duty_b;
  logic          tick;
  logic          wrap;
  logic          pwm_r_nxt;
  logic          pwm_g_nxt;
  logic          pwm_b_nxt;

  assign tick = (presc == PRESC_MAX);
  // cnt idles at 8'hFF while disarmed, so the first enabled edge is always a wrap
  assign wrap = tick && (cnt == 8'hFF);

  always_comb begin
    pwm_r_nxt = 1'b0;
    pwm_g_nxt = 1'b0;
    pwm_b_nxt = 1'b0;
`ifdef FULL_ON_EN
    pwm_r_nxt = (duty_r == 8'hFF) || (cnt < duty_r);
    pwm_g_nxt = (duty_g == 8'hFF) || (cnt < duty_g);
    pwm_b_nxt = (duty_b == 8'hFF) || (cnt < duty_b);
`else
    pwm_r_nxt = (cnt < duty_r);
    pwm_g_nxt = (cnt < duty_g);
    pwm_b_nxt = (cnt < duty_b);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      presc        <= PRESC_MAX;
      cnt          <= 8'hFF;
      duty_r       <= '0;
      duty_g       <= '0;
      duty_b       <= '0;
      pwm_r        <= 1'b0;
      pwm_g        <= 1'b0;
      pwm_b        <= 1'b0;
      period_start <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        cnt <= cnt + 8'd1;
      end
      // shadow duties only move at the period boundary
      if (wrap) begin
        duty_r <= light[23:16];
        duty_g <= light[15:8];
        duty_b <= light[7:0];
      end
      period_start <= wrap;
      pwm_r        <= pwm_r_nxt;
      pwm_g        <= pwm_g_nxt;
      pwm_b        <= pwm_b_nxt;
    end
  end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Scoreboard bench for rgb_pwm_driver: two instances (PRESCALE 1 and 4), per-period
// high-count expectations queued by the stimulus and checked by one negedge monitor.
module tb_rgb_pwm_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0 = 1'b1, en0 = 1'b0;
  logic [23:0] light0 = '0;
  logic [2:0]  pwm0;
  logic        ps0;
  logic        rst1 = 1'b1, en1 = 1'b0;
  logic [23:0] light1 = '0;
  logic [2:0]  pwm1;
  logic        ps1;

  rgb_pwm_driver #(.PRESCALE(1)) u0 (
    .clk(clk), .rst(rst0), .enable(en0), .light(light0),
    .pwm_r(pwm0[2]), .pwm_g(pwm0[1]), .pwm_b(pwm0[0]), .period_start(ps0)
  );

  rgb_pwm_driver #(.PRESCALE(4)) u1 (
    .clk(clk), .rst(rst1), .enable(en1), .light(light1),
    .pwm_r(pwm1[2]), .pwm_g(pwm1[1]), .pwm_b(pwm1[0]), .period_start(ps1)
  );

  typedef struct {
    int len;
    int r;
    int g;
    int b;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int nvec = 0;
  int nmis = 0;
  bit fin0 = 1'b0;
  bit fin1 = 1'b0;

  function automatic exp_t mk(int len, int r, int g, int b);
    exp_t e;
    e.len = len; e.r = r; e.g = g; e.b = b;
    return e;
  endfunction

  // white: 255 steps high without full-on, whole period with it
  function automatic int ff_cnt(int p);
`ifdef FULL_ON_EN
    return 256 * p;
`else
    return 255 * p;
`endif
  endfunction

  function automatic void chk(string nm, int g, int act, int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL u%0d %s: got %0d expected %0d at %0t", g, nm, act, exp, $time);
    end
  endfunction

  task automatic step0(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // PRESCALE=1 stimulus
  initial begin
    step0(2);
    rst0 = 1'b0; en0 = 1'b1; light0 = 24'h80_40_00;
    q0.push_back(mk(256, 128, 64, 0));
    q0.push_back(mk(256, 128, 64, 0));
    step0(1 + 256 + 10);                    // period 2, cnt=10
    light0 = 24'h10_20_30;
    q0.push_back(mk(256, 16, 32, 48));
    step0(256 + 90);                        // period 3, cnt=100
    light0 = 24'hF0_00_01;
    q0.push_back(mk(256, 240, 0, 1));
    step0(256);                             // period 4, cnt=100
    light0 = 24'hFF_FF_FF;
    for (int i = 0; i < 3; i++) q0.push_back(mk(256, ff_cnt(1), ff_cnt(1), ff_cnt(1)));
    step0(3 * 256);                         // period 7, cnt=100
    light0 = 24'h64_64_64;
    step0(206);                             // period 8, cnt=50
    en0 = 1'b0;
    step0(10);
    en0 = 1'b1; light0 = 24'h0A_0A_0A;
    q0.push_back(mk(256, 10, 10, 10));
    step0(1 + 256 + 200);                   // period 10, cnt=200
    rst0 = 1'b1;
    step0(1);
    rst0 = 1'b0; light0 = 24'h03_FE_80;
    q0.push_back(mk(256, 3, 254, 128));
    step0(1 + 255);                         // period 11, cnt=255: change lands on the wrap edge
    light0 = 24'h20_08_10;
    q0.push_back(mk(256, 32, 8, 16));
    step0(257 + 5);
    en0 = 1'b0;
    step0(3);
    fin0 = 1'b1;
  end

  // PRESCALE=4 stimulus
  initial begin
    step0(3);
    rst1 = 1'b0; en1 = 1'b1; light1 = 24'h02_00_FF;
    for (int i = 0; i < 3; i++) q1.push_back(mk(1024, 8, 0, ff_cnt(4)));
    step0(1 + 3 * 1024 + 10);
    en1 = 1'b0;
    step0(3);
    fin1 = 1'b1;
  end

  bit armed [2] = '{1'b0, 1'b0};
  bit blkp  [2] = '{1'b1, 1'b1};
  bit rearm [2] = '{1'b0, 1'b0};
  int len   [2] = '{0, 0};
  int bad   [2] = '{0, 0};
  int hi    [2][3];
  bit sl    [2][3];
  bit ended = 1'b0;

  always @(negedge clk) begin
    logic       blk;
    logic [2:0] pw;
    logic       ps;
    exp_t       e;
    for (int g = 0; g < 2; g++) begin
      blk = (g == 0) ? (rst0 || !en0) : (rst1 || !en1);
      pw  = (g == 0) ? pwm0 : pwm1;
      ps  = (g == 0) ? ps0 : ps1;
      if (blkp[g]) begin
        chk("off_pwm", g, int'(pw), 0);
        chk("off_period_start", g, int'(ps), 0);
        armed[g] = 1'b0;
      end else begin
        if (rearm[g]) chk("first_wrap", g, int'(ps), 1);
        if (armed[g]) begin
          len[g]++;
          for (int c = 0; c < 3; c++) begin
            if (pw[c]) begin
              hi[g][c]++;
              if (sl[g][c]) bad[g]++;
            end else begin
              sl[g][c] = 1'b1;
            end
          end
        end
        if (ps) begin
          if (armed[g]) begin
            if ((g == 0 ? q0.size() : q1.size()) == 0) begin
              chk("extra_period", g, 0, 1);
            end else begin
              if (g == 0) e = q0.pop_front();
              else        e = q1.pop_front();
              chk("period_len", g, len[g], e.len);
              chk("high_r", g, hi[g][2], e.r);
              chk("high_g", g, hi[g][1], e.g);
              chk("high_b", g, hi[g][0], e.b);
              chk("pulse_shape", g, bad[g], 0);
            end
          end
          armed[g] = 1'b1;
          len[g] = 0;
          bad[g] = 0;
          for (int c = 0; c < 3; c++) begin
            hi[g][c] = 0;
            sl[g][c] = 1'b0;
          end
        end
      end
      rearm[g] = blkp[g] && !blk;
      blkp[g]  = blk;
    end
    if (fin0 && fin1 && !ended) begin
      ended = 1'b1;
      chk("periods_left", 0, q0.size(), 0);
      chk("periods_left", 1, q1.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete (got timeout, expected completion)");
    $fatal(1);
  end

endmodule

// File: doc/rgb_pwm_driver.md
Name: rgb_pwm_driver

Overview:
- Consumes the 24-bit RGB colour word produced by the lights selector stage and drives three PWM outputs for a physical RGB LED.
- Byte mapping: red = light[23:16], green = light[15:8], blue = light[7:0].
- Each 8-bit byte sets the duty cycle of its channel over a 256-step period.
- A new colour is sampled only at period boundaries, so a colour change never produces a truncated or stretched pulse.

Parameters:
- PRESCALE, 1: clock cycles per PWM step; must be >= 1. PWM period = 256*PRESCALE clk cycles.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  run PWM; low forces all outputs off and re-arms the period.
- light  input  24  RGB colour word from the selector ({R,G,B}).
- pwm_r  output  1  red PWM, registered.
- pwm_g  output  1  green PWM, registered.
- pwm_b  output  1  blue PWM, registered.
- period_start  output  1  one-cycle pulse, asserted in the first cycle of each PWM period, registered.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- State registers:
  - presc: counts 0..PRESCALE-1.
  - cnt[7:0]: step counter.
  - duty_r, duty_g, duty_b [7:0]: shadow duty registers.
- Reset or enable low (rst has priority; both checked at the clk edge):
  - presc <= PRESCALE-1, cnt <= 8'hFF, duty_* <= 0.
  - pwm_* <= 0, period_start <= 0.
- tick = (presc == PRESCALE-1).
- When enabled, on every edge:
  - presc <= tick ? 0 : presc+1.
  - If tick: cnt <= cnt+1, with 8'hFF wrapping to 8'h00.
  - Wrap edge (tick && cnt==8'hFF): duty_r/g/b <= light[23:16]/[15:8]/[7:0] and period_start <= 1; on every other edge period_start <= 0.
  - pwm_x <= (cnt < duty_x), evaluated on the pre-edge register values.
- Latency:
  - The first enabled edge after reset or disable is always a wrap edge.
  - period_start is high in the cycle where cnt first reads 0.
  - pwm_x follows cnt by exactly one clk cycle.
- Duty rules:
  - Channel high for exactly duty_x*PRESCALE cycles per period (duty 0 means never high; 255 means high 255 of 256 steps).
  - Unsigned 8-bit compare; no rounding.
- Boundaries:
  - light changes mid-period are ignored until the next wrap edge.
  - light changing on the wrap edge itself: the value present at that edge is captured.
  - enable dropping mid-period: outputs are 0 from the next cycle; on re-enable, a fresh full period starts with the current light.
  - rst mid-period: same as the disabled state.
  - PRESCALE=1: tick is constantly 1.

Optional Feature:
- Macro FULL_ON_EN.
- Defined: pwm_x <= (duty_x == 8'hFF) || (cnt < duty_x). White 24'hFFFFFF then holds all three outputs continuously high while enabled, except the single cycle after re-arm (duty_x is 0 until the first wrap).
- Undefined: plain compare only; duty 8'hFF gives a 1-step low pulse each period.

Test Plan:
- PRESCALE=1, rst 2 cycles, enable=1, light=24'h80_40_00:
  - period_start pulses every 256 cycles.
  - Per period: pwm_r high 128 cycles, pwm_g high 64 cycles, pwm_b never high.
  - pwm rising edges occur one cycle after period_start.
- light=24'h10_20_30, switched to 24'hF0_00_01 at cnt=100:
  - Current period keeps 16/32/48 high counts.
  - Next period (after period_start) gives 240/0/1.
- light=24'hFFFFFF:
  - Without FULL_ON_EN: each output low exactly 1 cycle per 256.
  - With FULL_ON_EN: outputs stay high across at least 3 periods after the first wrap.
- enable dropped at cnt=50 with light=24'h646464, held low 10 cycles, then raised with light=24'h0A0A0A:
  - All pwm=0 from the cycle after the drop.
  - Re-enable: period_start in the 1st enabled cycle, then 10-cycle high pulses.
- rst asserted at cnt=200 while outputs are active:
  - Next cycle: all outputs 0 and period_start 0.
  - After release with enable=1: period_start in the 1st cycle, normal waveform.
- PRESCALE=4, light=24'h02_00_FF:
  - Period 1024 cycles.
  - pwm_r high 8 cycles, pwm_g never high, pwm_b high 1020 cycles per period.
